// File: rtl/fnd_scan.sv
// Multi-digit seven-segment scan driver, double-buffered load; FND_LZB_EN adds leading-zero blanking.
// Latency: seg/dp/com registered one cycle after digit_idx/active data; shadow commits on frame_tick.
// Backpressure: ready=0 while the shadow holds an uncommitted value; load is ignored then.
module fnd_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int HEX_MODE     = 0,
  parameter int POLARITY_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     com
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic          INV      = (POLARITY_LOW != 0);

  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         digit_idx;
  logic [4*DIGITS-1:0]   active, shadow;
  logic [DIGITS-1:0]     active_dp, shadow_dp;
  logic                  shadow_full;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [DIGITS-1:0]     com_r;

  logic div_last, idx_last, frame_tick, accept, commit, blank_cur;
  logic [3:0] cur_code;

  assign div_last   = (div_cnt == DIV_LAST);
  assign idx_last   = (digit_idx == IDX_LAST);
  assign frame_tick = en && div_last && idx_last;
  assign accept     = load && !shadow_full;
  // With the display off there is no frame to tear, so commit right away.
  assign commit     = shadow_full && (frame_tick || !en);
  assign ready      = !shadow_full;
  assign cur_code   = active[4*int'(digit_idx) +: 4];

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    if (HEX_MODE == 0 && c > 4'd9) s = 7'h40;
    return s;
  endfunction

`ifdef FND_LZB_EN
  logic [DIGITS-1:0] blank;
  logic              zero_run;
  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (active[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end
  assign blank_cur = blank[digit_idx];
`else
  assign blank_cur = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (!en) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_last) begin
      div_cnt   <= '0;
      digit_idx <= idx_last ? '0 : digit_idx + 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // accept and commit are mutually exclusive: one needs the shadow empty, the other full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      shadow_dp   <= '0;
      shadow_full <= 1'b0;
      active      <= '0;
      active_dp   <= '0;
    end else if (accept) begin
      shadow      <= din;
      shadow_dp   <= dp_in;
      shadow_full <= 1'b1;
    end else if (commit) begin
      active      <= shadow;
      active_dp   <= shadow_dp;
      shadow_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= '0;
      dp_r  <= 1'b0;
      com_r <= '0;
    end else if (!en) begin
      seg_r <= '0;
      dp_r  <= 1'b0;
      com_r <= '0;
    end else begin
      seg_r <= blank_cur ? 7'h00 : decode(cur_code);
      dp_r  <= active_dp[digit_idx];
      com_r <= DIGITS'(1) << digit_idx;
    end
  end

  // Internal state is active-high; polarity is applied at the pins so reset lands on the idle level.
  assign seg = seg_r ^ {7{INV}};
  assign dp  = dp_r ^ INV;
  assign com = com_r ^ {DIGITS{INV}};

endmodule

// File: tb/tb_fnd_scan.sv
// Directed bench for fnd_scan (DIGITS=4, SCAN_DIV=4): default, hex-mode and active-low instances share stimulus.
module tb_fnd_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;

  logic       ready0, readyh, readyp;
  logic [6:0] seg0, segh, segp;
  logic       dp0, dph, dpp;
  logic [3:0] com0, comh, comp;

  int tests = 0;
  int fails = 0;
  int k = 0;

`ifdef FND_LZB_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  fnd_scan #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .POLARITY_LOW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .dp_in(dp_in),
    .ready(ready0), .seg(seg0), .dp(dp0), .com(com0));
  fnd_scan #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .POLARITY_LOW(0)) duth (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .dp_in(dp_in),
    .ready(readyh), .seg(segh), .dp(dph), .com(comh));
  fnd_scan #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .POLARITY_LOW(1)) dutp (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .dp_in(dp_in),
    .ready(readyp), .seg(segp), .dp(dpp), .com(comp));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    k += n;
  endtask

  // Called at the first output cycle of a frame; segs/hsegs pack digit3..digit0.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [27:0] hsegs, input logic [3:0] dps);
    for (int c = 0; c < 16; c++) begin
      int d;
      logic [3:0] cm, cmn;
      logic [6:0] s, sn, sh;
      logic dn;
      d   = c / 4;
      cm  = 4'b0001 << d;
      cmn = ~cm;
      s   = segs[d*7 +: 7];
      sn  = ~s;
      sh  = hsegs[d*7 +: 7];
      dn  = ~dps[d];
      chk($sformatf("%s d%0d c%0d com", tag, d, c), com0, cm);
      chk($sformatf("%s d%0d c%0d seg", tag, d, c), seg0, s);
      chk($sformatf("%s d%0d c%0d dp", tag, d, c), dp0, dps[d]);
      chk($sformatf("%s d%0d c%0d hex_seg", tag, d, c), segh, sh);
      chk($sformatf("%s d%0d c%0d low_com", tag, d, c), comp, cmn);
      chk($sformatf("%s d%0d c%0d low_seg", tag, d, c), segp, sn);
      chk($sformatf("%s d%0d c%0d low_dp", tag, d, c), dpp, dn);
      step(1);
    end
  endtask

  initial begin
    // Reset state, including the active-low idle levels.
    #1 rst_n = 1'b0;
    #2;
    chk("rst seg", seg0, 7'h00);
    chk("rst dp", dp0, 1'b0);
    chk("rst com", com0, 4'h0);
    chk("rst ready", ready0, 1'b1);
    chk("rst low_com", comp, 4'hF);
    chk("rst low_seg", segp, 7'h7F);
    chk("rst low_dp", dpp, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;

    // Hex scan of 1234 with dp on digit 2.
    step(1);
    chk("first com", com0, 4'b0001);
    chk("first seg", seg0, 7'h3F);
    load = 1'b1; din = 16'h1234; dp_in = 4'b0100;
    step(1);
    load = 1'b0;
    chk("1234 ready low", ready0, 1'b0);
    step(15);
    chk("1234 ready back", ready0, 1'b1);
    check_frame("f1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100);

    // BCD dash vs hex A.
    load = 1'b1; din = 16'h00A9; dp_in = 4'b0000;
    step(1);
    load = 1'b0;
    step(15);
    check_frame("f00A9", {LZ, LZ, 7'h40, 7'h6F}, {LZ, LZ, 7'h77, 7'h6F}, 4'b0000);

    // Second load while ready=0 is dropped.
    load = 1'b1; din = 16'h1111;
    step(1);
    din = 16'h2222;
    step(4);
    load = 1'b0;
    chk("1111 ready low", ready0, 1'b0);
    step(11);
    check_frame("f1111a", {4{7'h06}}, {4{7'h06}}, 4'b0000);
    check_frame("f1111b", {4{7'h06}}, {4{7'h06}}, 4'b0000);

    // Load on the frame_tick cycle waits one full frame.
    step(14);
    load = 1'b1; din = 16'h5678;
    step(1);
    load = 1'b0;
    chk("tick ready low", ready0, 1'b0);
    step(1);
    check_frame("ftick_old", {4{7'h06}}, {4{7'h06}}, 4'b0000);
    chk("tick ready back", ready0, 1'b1);
    check_frame("f5678", {7'h6D, 7'h7D, 7'h07, 7'h7F}, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0000);

    // Disable: blank outputs and commit without scanning.
    load = 1'b1; din = 16'h0978;
    step(1);
    load = 1'b0; en = 1'b0;
    chk("en0 ready low", ready0, 1'b0);
    step(1);
    chk("en0 ready back", ready0, 1'b1);
    step(1);
    chk("en0 com", com0, 4'h0);
    chk("en0 seg", seg0, 7'h00);
    chk("en0 dp", dp0, 1'b0);
    chk("en0 low_com", comp, 4'hF);
    chk("en0 low_seg", segp, 7'h7F);
    step(3);
    chk("en0 hold com", com0, 4'h0);
    en = 1'b1;
    step(1);
    check_frame("f0978", {LZ, 7'h6F, 7'h07, 7'h7F}, {LZ, 7'h6F, 7'h07, 7'h7F}, 4'b0000);

    // Async reset mid-handshake drops the pending shadow.
    load = 1'b1; din = 16'h4444; dp_in = 4'b1111;
    step(1);
    load = 1'b0; dp_in = 4'b0000;
    chk("pend ready low", ready0, 1'b0);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst ready", ready0, 1'b1);
    chk("mid rst com", com0, 4'h0);
    chk("mid rst seg", seg0, 7'h00);
    chk("mid rst dp", dp0, 1'b0);
    chk("mid rst low_com", comp, 4'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    step(16);
    chk("post rst ready", ready0, 1'b1);
    step(1);
    check_frame("fzero", {LZ, LZ, LZ, 7'h3F}, {LZ, LZ, LZ, 7'h3F}, 4'b0000);

    // Leading-zero patterns.
    load = 1'b1; din = 16'h0042;
    step(1);
    load = 1'b0;
    step(15);
    check_frame("f0042", {LZ, LZ, 7'h66, 7'h5B}, {LZ, LZ, 7'h66, 7'h5B}, 4'b0000);
    load = 1'b1; din = 16'h0400;
    step(1);
    load = 1'b0;
    step(15);
    check_frame("f0400", {LZ, 7'h66, 7'h3F, 7'h3F}, {LZ, 7'h66, 7'h3F, 7'h3F}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
